heartbeat_watchdog: RTL and testbench

- Safety watchdog for the AM-radio FPGA datapath.
- Counts clock cycles since the last heartbeat from the control processor.
- Raises `warning` when the count nears timeout, then a sticky `triggered` flag at timeout.
- Downstream logic uses `triggered` to mute the RF output until software explicitly clears it.

---
 rtl/heartbeat_watchdog.sv | 80 ++++++++
 tb/tb_heartbeat_watchdog.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/heartbeat_watchdog.sv
// Heartbeat watchdog: counts cycles since the last keep-alive, flags warning, then a sticky trigger.
// Define WATCHDOG_HEARTBEAT_EDGE_EN to count only rising edges of heartbeat.
module heartbeat_watchdog #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd625_000_000,
  parameter logic [31:0] WARN_CYCLES    = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        heartbeat,
  input  logic        force_reset,
  output logic [31:0] counter,
  output logic        warning,
  output logic        triggered
);

  if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
    $fatal(1, "heartbeat_watchdog: TIMEOUT_CYCLES must be at least 2");
  end
  if (WARN_CYCLES < 32'd1 || WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_warn
    $fatal(1, "heartbeat_watchdog: WARN_CYCLES must be in 1..TIMEOUT_CYCLES-1");
  end

  logic        hb_event;
  logic [31:0] count_inc;
  logic [31:0] counter_next;
  logic        warning_next;
  logic        triggered_next;

`ifdef WATCHDOG_HEARTBEAT_EDGE_EN
  // A stuck-high heartbeat must not keep the watchdog alive, so only 0->1 counts.
  logic heartbeat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) heartbeat_q <= 1'b0;
    else     heartbeat_q <= heartbeat;
  end

  assign hb_event = heartbeat & ~heartbeat_q;
`else
  assign hb_event = heartbeat;
`endif

  assign count_inc = counter + 32'd1;

  always_comb begin
    counter_next   = counter;
    warning_next   = warning;
    triggered_next = triggered;
    if (!enable || force_reset) begin
      counter_next   = '0;
      warning_next   = 1'b0;
      triggered_next = 1'b0;
    end else if (triggered) begin
      counter_next = TIMEOUT_CYCLES;
      warning_next = 1'b1;
    end else if (hb_event) begin
      counter_next = '0;
      warning_next = 1'b0;
    end else begin
      // Flags follow the incremented value so they rise on the same edge.
      counter_next   = count_inc;
      warning_next   = warning | (count_inc >= WARN_CYCLES);
      triggered_next = (count_inc == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      counter   <= counter_next;
      warning   <= warning_next;
      triggered <= triggered_next;
    end
  end

endmodule

// File: tb/tb_heartbeat_watchdog.sv
// Directed self-checking bench for heartbeat_watchdog with TIMEOUT_CYCLES=16, WARN_CYCLES=12.
module tb_heartbeat_watchdog;

  localparam logic [31:0] TO = 32'd16;
  localparam logic [31:0] WN = 32'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic [31:0] counter;
  logic        warning;
  logic        triggered;

  int checks = 0;
  int errors = 0;

  heartbeat_watchdog #(.TIMEOUT_CYCLES(TO), .WARN_CYCLES(WN)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .heartbeat(heartbeat),
    .force_reset(force_reset),
    .counter(counter),
    .warning(warning),
    .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] c, input logic w, input logic t);
    check_val({tag, "_cnt"}, counter, c);
    check_val({tag, "_warn"}, {31'd0, warning}, {31'd0, w});
    check_val({tag, "_trig"}, {31'd0, triggered}, {31'd0, t});
  endtask

  task automatic clear_wd();
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    rst = 1'b1; enable = 1'b1; heartbeat = 1'b1; force_reset = 1'b0;
    #1;
    check_all("rst_async", 32'd0, 1'b0, 1'b0);
    repeat (3) tick();
    check_all("rst_hold", 32'd0, 1'b0, 1'b0);
    heartbeat = 1'b0; rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("count_up", counter, 32'(k));
    end

    clear_wd();
    check_all("fr_clear", 32'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_all("timeout", (e >= 16) ? 32'd16 : 32'(e), e >= 12, e >= 16);
    end

    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    check_all("sticky_hb", 32'd16, 1'b1, 1'b1);
    clear_wd();
    check_all("sticky_fr", 32'd0, 1'b0, 1'b0);
    tick();
    check_val("resume", counter, 32'd1);

    clear_wd();
    exp_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      heartbeat = (i % 10 == 0);
      tick();
      exp_cnt = heartbeat ? 32'd0 : exp_cnt + 32'd1;
      check_all("keepalive", exp_cnt, 1'b0, 1'b0);
    end
    heartbeat = 1'b0;

    repeat (15) tick();
    check_all("pre_to", 32'd15, 1'b1, 1'b0);
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    check_all("hb_at_to", 32'd0, 1'b0, 1'b0);

    repeat (5) tick();
    check_val("pre_both", counter, 32'd5);
    heartbeat = 1'b1; force_reset = 1'b1;
    tick();
    heartbeat = 1'b0; force_reset = 1'b0;
    check_all("hb_and_fr", 32'd0, 1'b0, 1'b0);

    clear_wd();
    repeat (19) tick();
    check_all("pre_dis", 32'd16, 1'b1, 1'b1);
    enable = 1'b0; heartbeat = 1'b1;
    tick();
    check_all("disable", 32'd0, 1'b0, 1'b0);
    enable = 1'b1; heartbeat = 1'b0;
    tick();
    check_val("reenable", counter, 32'd1);

    repeat (3) tick();
    check_val("pre_arst", counter, 32'd4);
    rst = 1'b1;
    #1;
    check_all("arst_mid", 32'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;

    clear_wd();
    heartbeat = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
`ifdef WATCHDOG_HEARTBEAT_EDGE_EN
      check_all("hb_stuck", (i - 1 >= 16) ? 32'd16 : 32'(i - 1), i - 1 >= 12, i - 1 >= 16);
`else
      check_all("hb_level", 32'd0, 1'b0, 1'b0);
`endif
    end
    heartbeat = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
